// File: rtl/sphere_area_pipe.sv
// Purpose: channel-tagged radius stream to saturated area (4*pi*r^2 or pi*r^2), per-channel sticky overflow.
// Latency: a sample accepted at edge N shows out_valid=1 after edge N+3. Throughput is 1 sample/cycle.
// Backpressure: the whole pipe stalls when out_valid && !out_ready. in_ready is combinational from out_ready.
// Optional: define SPH_ROUND_EN to round half up instead of truncating before the saturation check.
module sphere_area_pipe #(
  parameter int RW   = 16,
  parameter int AW   = 26,
  parameter int CHW  = 2,
  parameter int FRAC = 12,
  parameter int PI_Q = 12868
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RW-1:0]       radius,
  input  logic [CHW-1:0]      in_ch,
  input  logic                mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [AW-1:0]       area,
  output logic [CHW-1:0]      out_ch,
  output logic                ovf,
  output logic [(2**CHW)-1:0] ovf_sticky,
  input  logic                clr_sticky
);

  localparam int NCH  = 2**CHW;
  localparam int KW   = 18;           // PI_Q (16 bits) scaled by 4
  localparam int SQW  = 2*RW;
  localparam int PW   = SQW + KW;
  // One spare bit above the product keeps the rounding add from wrapping
  localparam int RESW = PW + 1 - FRAC;

  localparam logic [KW-1:0] K_SPHERE = KW'(PI_Q) << 2;
  localparam logic [KW-1:0] K_DISC   = KW'(PI_Q);

`ifdef SPH_ROUND_EN
  localparam logic [PW:0] HALF = (PW+1)'(1) << (FRAC-1);
`endif

  // Global stall: every stage moves together or not at all
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1 registers
  logic            s1_vld;
  logic [RW-1:0]   s1_r;
  logic [CHW-1:0]  s1_ch;
  logic            s1_mode;

  // Stage 2 registers
  logic            s2_vld;
  logic [SQW-1:0]  s2_sq;
  logic [CHW-1:0]  s2_ch;
  logic            s2_mode;

  // Stage 3 product register. The wide multiply gets its own register and the
  // shift/saturate/sticky logic runs on its output, loading the result registers.
  logic            s3_vld;
  logic [PW-1:0]   s3_prod;
  logic [CHW-1:0]  s3_ch;

  // Combinational values between stages
  logic [SQW-1:0]  sq_next;
  logic [KW-1:0]   k_sel;
  logic [PW-1:0]   prod_next;
  logic [PW:0]     prod_adj;
  logic [RESW-1:0] res;
  logic            sat;
  logic [AW-1:0]   area_next;
  logic [NCH-1:0]  sticky_next;

  // Square the registered radius
  always_comb begin
    sq_next = {{RW{1'b0}}, s1_r} * {{RW{1'b0}}, s1_r};
  end

  // Pick the pi multiple for the sample's mode and form the full-width product
  always_comb begin
    k_sel     = s2_mode ? K_DISC : K_SPHERE;
    prod_next = {{KW{1'b0}}, s2_sq} * {{SQW{1'b0}}, k_sel};
  end

  // Drop the fractional bits, then clamp to the output width
  always_comb begin
`ifdef SPH_ROUND_EN
    prod_adj = {1'b0, s3_prod} + HALF;
`else
    prod_adj = {1'b0, s3_prod};
`endif
    res       = RESW'(prod_adj >> FRAC);
    sat       = |res[RESW-1:AW];
    area_next = sat ? {AW{1'b1}} : res[AW-1:0];
  end

  // Sticky update: a clear wipes every channel, but a saturated result landing
  // on the same edge still sets its own channel
  always_comb begin
    sticky_next = clr_sticky ? '0 : ovf_sticky;
    if (advance && s3_vld && sat) begin
      sticky_next[s3_ch] = 1'b1;
    end
  end

  // Stage 1: capture the accepted sample (bubble when in_valid is low)
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_r    <= '0;
      s1_ch   <= '0;
      s1_mode <= 1'b0;
    end else if (advance) begin
      s1_vld  <= in_valid;
      s1_r    <= radius;
      s1_ch   <= in_ch;
      s1_mode <= mode;
    end
  end

  // Stage 2: register r*r with its tag and mode
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_sq   <= '0;
      s2_ch   <= '0;
      s2_mode <= 1'b0;
    end else if (advance) begin
      s2_vld  <= s1_vld;
      s2_sq   <= sq_next;
      s2_ch   <= s1_ch;
      s2_mode <= s1_mode;
    end
  end

  // Stage 3 product: register sq*K with its tag
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_vld  <= 1'b0;
      s3_prod <= '0;
      s3_ch   <= '0;
    end else if (advance) begin
      s3_vld  <= s2_vld;
      s3_prod <= prod_next;
      s3_ch   <= s2_ch;
    end
  end

  // Result registers: hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      area      <= '0;
      out_ch    <= '0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= s3_vld;
      area      <= area_next;
      out_ch    <= s3_ch;
      ovf       <= sat;
    end
  end

  // Per-channel sticky overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= '0;
    end else begin
      ovf_sticky <= sticky_next;
    end
  end

endmodule

// File: tb/tb_sphere_area_pipe.sv
// Directed bench for sphere_area_pipe: reset, streaming, mode select, stall, mid-stream reset, sticky clear.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there or 1 unit later.
// Expected areas are hand-computed constants; the rounding build changes only the pi*1000^2 vector.
module tb_sphere_area_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] radius = '0;
  logic [1:0]  in_ch = '0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [25:0] area;
  logic [1:0]  out_ch;
  logic        ovf;
  logic [3:0]  ovf_sticky;
  logic        clr_sticky = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [25:0] AMAX = 26'd67108863;
`ifdef SPH_ROUND_EN
  localparam int A_DISC_1000 = 3141602;
`else
  localparam int A_DISC_1000 = 3141601;
`endif

  sphere_area_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .radius(radius), .in_ch(in_ch), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .area(area), .out_ch(out_ch), .ovf(ovf),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    vec_cnt++; if (area !== 26'd0) begin err_cnt++; $display("FAIL rst_area: got %0d expected 0", area); end
    vec_cnt++; if (out_ch !== 2'd0) begin err_cnt++; $display("FAIL rst_out_ch: got %0d expected 0", out_ch); end
    vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    vec_cnt++; if (ovf_sticky !== 4'b0000) begin err_cnt++; $display("FAIL rst_sticky: got %b expected 0000", ovf_sticky); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream;
    int          rads[4]    = '{1000, 2000, 4000, 250};
    int          exp_a[4]   = '{12566406, 50265625, 67108863, 785400};
    logic        exp_o[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; radius = 16'(rads[c]); in_ch = 2'(c); mode = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      step;
      if (c < 3 || c > 6) begin
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_idle_c%0d: out_valid %b expected 0", c, out_valid); end
      end else begin
        vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL stream_valid_%0d: got %b expected 1", c-3, out_valid); end
        vec_cnt++; if (area !== 26'(exp_a[c-3])) begin err_cnt++; $display("FAIL stream_area_%0d: got %0d expected %0d", c-3, area, exp_a[c-3]); end
        vec_cnt++; if (ovf !== exp_o[c-3]) begin err_cnt++; $display("FAIL stream_ovf_%0d: got %b expected %b", c-3, ovf, exp_o[c-3]); end
        vec_cnt++; if (out_ch !== 2'(c-3)) begin err_cnt++; $display("FAIL stream_ch_%0d: got %0d expected %0d", c-3, out_ch, c-3); end
      end
    end
    vec_cnt++; if (ovf_sticky !== 4'b0100) begin err_cnt++; $display("FAIL stream_sticky: got %b expected 0100", ovf_sticky); end
  endtask

  task automatic test_mode_zero;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin
        in_valid = 1'b1; radius = 16'd1000; in_ch = 2'd1; mode = 1'b1;
      end else if (c == 1) begin
        in_valid = 1'b1; radius = 16'd0; in_ch = 2'd3; mode = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      step;
      if (c == 3) begin
        vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL disc_valid: got %b expected 1", out_valid); end
        vec_cnt++; if (area !== 26'(A_DISC_1000)) begin err_cnt++; $display("FAIL disc_area: got %0d expected %0d", area, A_DISC_1000); end
        vec_cnt++; if (out_ch !== 2'd1) begin err_cnt++; $display("FAIL disc_ch: got %0d expected 1", out_ch); end
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL disc_ovf: got %b expected 0", ovf); end
      end else if (c == 4) begin
        vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL zero_valid: got %b expected 1", out_valid); end
        vec_cnt++; if (area !== 26'd0) begin err_cnt++; $display("FAIL zero_area: got %0d expected 0", area); end
        vec_cnt++; if (out_ch !== 2'd3) begin err_cnt++; $display("FAIL zero_ch: got %0d expected 3", out_ch); end
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL zero_ovf: got %b expected 0", ovf); end
      end else begin
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mz_idle_c%0d: out_valid %b expected 0", c, out_valid); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int          rads[8]  = '{1000, 2000, 250, 0, 2000, 250, 1000, 250};
    int          chs[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic        modes[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int          exp_a[8] = '{12566406, 50265625, 785400, 0, 12566406, 196350, 12566406, 785400};
    int          sent = 0;
    int          got  = 0;
    logic        prev_hold = 1'b0;
    logic [25:0] prev_area = '0;
    logic [1:0]  prev_ch   = '0;
    logic        exp_rdy;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 5 && c < 10);
      if (sent < 8) begin
        in_valid = 1'b1; radius = 16'(rads[sent]); in_ch = 2'(chs[sent]); mode = modes[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_hold) begin
        vec_cnt++;
        if (out_valid !== 1'b1 || area !== prev_area || out_ch !== prev_ch) begin
          err_cnt++;
          $display("FAIL b2b_hold_c%0d: got v=%b a=%0d ch=%0d expected v=1 a=%0d ch=%0d", c, out_valid, area, out_ch, prev_area, prev_ch);
        end
      end
      exp_rdy = !(out_valid === 1'b1 && !out_ready);
      vec_cnt++; if (in_ready !== exp_rdy) begin err_cnt++; $display("FAIL b2b_in_ready_c%0d: got %b expected %b", c, in_ready, exp_rdy); end
      if (out_valid === 1'b1 && out_ready) begin
        if (got < 8) begin
          vec_cnt++; if (area !== 26'(exp_a[got])) begin err_cnt++; $display("FAIL b2b_area_%0d: got %0d expected %0d", got, area, exp_a[got]); end
          vec_cnt++; if (out_ch !== 2'(chs[got])) begin err_cnt++; $display("FAIL b2b_ch_%0d: got %0d expected %0d", got, out_ch, chs[got]); end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      prev_hold = (out_valid === 1'b1) && !out_ready;
      prev_area = area;
      prev_ch   = out_ch;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vec_cnt++; if (sent != 8) begin err_cnt++; $display("FAIL b2b_sent: got %0d expected 8", sent); end
    vec_cnt++; if (got != 8) begin err_cnt++; $display("FAIL b2b_received: got %0d expected 8", got); end
  endtask

  task automatic test_reset_midstream;
    int rads[3] = '{1000, 4000, 250};
    int chs[3]  = '{0, 3, 1};
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; radius = 16'(rads[c]); in_ch = 2'(chs[c]); mode = 1'b0;
      step;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    vec_cnt++; if (ovf_sticky !== 4'b0000) begin err_cnt++; $display("FAIL midrst_sticky: got %b expected 0000", ovf_sticky); end
    vec_cnt++; if (area !== 26'd0) begin err_cnt++; $display("FAIL midrst_area: got %0d expected 0", area); end
    for (int c = 0; c < 5; c++) begin
      vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_drop_c%0d: out_valid %b expected 0", c, out_valid); end
      vec_cnt++; if (ovf_sticky !== 4'b0000) begin err_cnt++; $display("FAIL midrst_sticky_c%0d: got %b expected 0000", c, ovf_sticky); end
      step;
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        in_valid = 1'b1; radius = 16'd250; in_ch = 2'd1; mode = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      step;
      if (c < 3) begin
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_lat_c%0d: out_valid %b expected 0", c, out_valid); end
      end else begin
        vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL midrst_valid: got %b expected 1", out_valid); end
        vec_cnt++; if (area !== 26'd785400) begin err_cnt++; $display("FAIL midrst_area_out: got %0d expected 785400", area); end
        vec_cnt++; if (out_ch !== 2'd1) begin err_cnt++; $display("FAIL midrst_ch: got %0d expected 1", out_ch); end
      end
    end
  endtask

  task automatic test_sticky_clr;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c == 0); radius = 16'd4000; in_ch = 2'd1; mode = 1'b0;
      step;
    end
    vec_cnt++; if (ovf_sticky !== 4'b0010) begin err_cnt++; $display("FAIL sticky_ch1: got %b expected 0010", ovf_sticky); end
    for (int c = 0; c < 4; c++) begin
      in_valid = (c == 0); radius = 16'd4000; in_ch = 2'd2; mode = 1'b0;
      clr_sticky = (c == 3);
      step;
      if (c == 2) begin
        vec_cnt++; if (ovf_sticky !== 4'b0010) begin err_cnt++; $display("FAIL sticky_pre: got %b expected 0010", ovf_sticky); end
      end
    end
    clr_sticky = 1'b0;
    vec_cnt++; if (ovf_sticky !== 4'b0100) begin err_cnt++; $display("FAIL sticky_set_wins: got %b expected 0100", ovf_sticky); end
    vec_cnt++; if (out_valid !== 1'b1 || ovf !== 1'b1) begin err_cnt++; $display("FAIL sticky_sat_flag: got v=%b ovf=%b expected 1 1", out_valid, ovf); end
    vec_cnt++; if (area !== AMAX) begin err_cnt++; $display("FAIL sticky_sat_area: got %0d expected %0d", area, AMAX); end
    vec_cnt++; if (out_ch !== 2'd2) begin err_cnt++; $display("FAIL sticky_sat_ch: got %0d expected 2", out_ch); end
    clr_sticky = 1'b1;
    step;
    clr_sticky = 1'b0;
    vec_cnt++; if (ovf_sticky !== 4'b0000) begin err_cnt++; $display("FAIL sticky_clear: got %b expected 0000", ovf_sticky); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_mode_zero;
    test_back_to_back;
    test_reset_midstream;
    test_sticky_clr;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sphere_area_pipe.md
Name: sphere_area_pipe

Overview:
- Parametrised, pipelined successor of the single-channel Sphere_To_Cart radius-to-area block.
- Accepts a stream of channel-tagged radius samples and returns 4·π·r² (sphere surface) or π·r² (cross-section), selected per sample.
- Fixed-point arithmetic with saturation, valid/ready handshakes on both sides, per-channel sticky overflow flags.
- Sits between the range-sample source and the area consumer/logging path.

Parameters:
- RW, 16, radius width (unsigned integer).
- AW, 26, area output width.
- CHW, 2, channel tag width; NCH = 2**CHW channels.
- FRAC, 12, fractional bits of PI_Q.
- PI_Q, 12868, π in unsigned Q(FRAC) format (round(π·4096)); must fit in 16 bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- radius  in  RW  unsigned radius.
- in_ch  in  CHW  channel tag.
- mode  in  1  0: 4πr², 1: πr².
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- area  out  AW  result, saturated.
- out_ch  out  CHW  channel tag of result.
- ovf  out  1  this result saturated.
- ovf_sticky  out  NCH  per-channel sticky overflow flags.
- clr_sticky  in  1  one-cycle pulse; clears ovf_sticky.

Behaviour:
- Reset: out_valid=0, area=0, out_ch=0, ovf=0, ovf_sticky=0. All stage valids are cleared and in-flight samples are dropped, including on reset mid-stream. in_ready=1 in the first cycle after reset.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Pipeline: 3 stages, globally stalled.
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - S1 registers radius, in_ch, mode and valid.
  - S2 computes sq = r·r (2·RW bits).
  - S3 computes the product, shift, saturation, ovf and sticky update.
  - When advance=0, every stage holds its contents and outputs are stable.
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N+3 if out_ready stayed high. Throughput is 1 sample/cycle.
- Arithmetic:
  - K = PI_Q<<2 for mode=0, K = PI_Q for mode=1.
  - prod = sq·K in 2·RW+18 bits.
  - res = prod >> FRAC (truncation).
  - If res > 2**AW−1, then area = 2**AW−1 and ovf=1; otherwise area = res[AW−1:0] and ovf=0.
- Sticky flags: ovf_sticky[out_ch] is set in the cycle a saturated result enters S3 (not on output transfer).
  - clr_sticky clears all flags.
  - If a set and clr_sticky coincide, set wins for that channel; the others clear.
- Bubbles: invalid input cycles propagate as bubbles. The area/out_ch values under out_valid=0 are don't-care except after reset (0).
- Edge cases:
  - radius=0 gives area=0, ovf=0.
  - Maximum radius with mode=0 saturates for default widths.
  - While stalled, in_ready=0 and new inputs are ignored.

Optional Feature:
- Macro SPH_ROUND_EN.
- Defined: res = (prod + 2**(FRAC−1)) >> FRAC (round half up) before the saturation check.
- Undefined: plain truncation as above.
- Latency, handshakes and flags are identical in both builds.

Test Plan:
- Reset, then stream r=1000,2000,4000,250 on ch 0..3 with mode=0 and out_ready=1 → after 3 cycles, consecutive outputs:
  - 12566406, ovf=0
  - 50265625, ovf=0
  - 67108863, ovf=1
  - 785400, ovf=0
  - out_ch=0,1,2,3; ovf_sticky=4'b0100.
- r=1000 with mode=1 → area=3141601 (SPH_ROUND_EN: 3141602); r=0 → area=0.
- Back-to-back stream with out_ready low for 5 cycles mid-stream → in_ready low the same cycles, out_valid and area held, no sample lost or duplicated, order preserved.
- Assert rst for 1 cycle with 3 samples in flight → no out_valid afterward until new input; ovf_sticky=0; next sample r=250 returns 785400 at latency 3.
- Saturating sample on ch 2 coinciding with clr_sticky, with ch 1 previously set → ovf_sticky=4'b0100.
- SPH_ROUND_EN build: r=1000 mode=0 → 12566406; r=250 mode=0 → 785400; r=1000 mode=1 → 3141602.
